seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller driving the 4-digit seven-segment decoder's num/digit/en inputs.
//  - Holds a 16-bit display word (four nibbles) and steps the active digit at a fixed refresh rate.
//  - Applies an anti-ghosting guard blank at the start of each digit slot.
//  - Updates the displayed word only at frame boundaries, so a frame never mixes old and new values.

---
 rtl/seven_seg_scan_ctrl.sv | 106 ++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit seven-segment scan controller with guard blanking and frame-aligned updates
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [3:0]  num,
  output logic [1:0]  digit,
  output logic        en,
  output logic        frame_done
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GUARD_T  = TW'(GUARD);

  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [1:0]    digit_nxt;
  logic [15:0]   act_word, act_word_nxt, pend_word, pend_word_nxt;
  logic [3:0]    act_mask, act_mask_nxt, pend_mask, pend_mask_nxt;
  logic          pend_valid, pend_valid_nxt;
  logic          boundary;
  logic [3:0]    nib, num_nxt;
  logic          en_nxt;
`ifdef SEVSEG_LZB_EN
  logic [3:0]    lz;
`endif

  always_comb begin
    tick_nxt       = tick_cnt + 1'b1;
    digit_nxt      = digit;
    boundary       = 1'b0;
    act_word_nxt   = act_word;
    act_mask_nxt   = act_mask;
    pend_word_nxt  = pend_word;
    pend_mask_nxt  = pend_mask;
    pend_valid_nxt = pend_valid;

    if (tick_cnt == TICK_MAX) begin
      tick_nxt  = '0;
      digit_nxt = digit + 2'd1;
      boundary  = (digit == 2'd3);
    end

    // A load landing on the boundary edge goes straight to the active word.
    if (boundary && load) begin
      act_word_nxt   = value;
      act_mask_nxt   = digit_en;
      pend_valid_nxt = 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        act_word_nxt   = pend_word;
        act_mask_nxt   = pend_mask;
        pend_valid_nxt = 1'b0;
      end
      if (load) begin
        pend_word_nxt  = value;
        pend_mask_nxt  = digit_en;
        pend_valid_nxt = 1'b1;
      end
    end

    nib     = act_word_nxt[{digit_nxt, 2'b00} +: 4];
    num_nxt = (nib >= 4'hB && nib <= 4'hE) ? 4'hF : nib;
`ifdef SEVSEG_LZB_EN
    lz[3] = (act_word_nxt[15:12] == 4'h0);
    lz[2] = lz[3] && (act_word_nxt[11:8] == 4'h0);
    lz[1] = lz[2] && (act_word_nxt[7:4] == 4'h0);
    lz[0] = 1'b0;
    if (lz[digit_nxt]) num_nxt = 4'hA;
`endif
    en_nxt = act_mask_nxt[digit_nxt] && ((GUARD == 0) || (tick_nxt >= GUARD_T));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      digit      <= 2'd0;
      act_word   <= 16'h0000;
      act_mask   <= 4'b0000;
      pend_word  <= 16'h0000;
      pend_mask  <= 4'b0000;
      pend_valid <= 1'b0;
      num        <= 4'h0;
      en         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tick_cnt   <= tick_nxt;
      digit      <= digit_nxt;
      act_word   <= act_word_nxt;
      act_mask   <= act_mask_nxt;
      pend_word  <= pend_word_nxt;
      pend_mask  <= pend_mask_nxt;
      pend_valid <= pend_valid_nxt;
      num        <= num_nxt;
      en         <= en_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed scoreboard bench for seven_seg_scan_ctrl (REFRESH_DIV=8, GUARD=2)
// Expected frames follow SEVSEG_LZB_EN when it is defined for the build.
module tb_seven_seg_scan_ctrl;

  typedef struct packed {
    logic [1:0] digit;
    logic [3:0] num;
    logic       en;
    logic       fd;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  digit_en = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  num;
  logic [1:0]  digit;
  logic        en;
  logic        frame_done;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  string tag = "reset";
  obs_t  exp_q[$];

  seven_seg_scan_ctrl #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .load(load),
    .num(num), .digit(digit), .en(en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_num(input logic [15:0] w, input int d);
    logic [3:0] n;
    n = w[d*4 +: 4];
    if (n >= 4'hB && n <= 4'hE) n = 4'hF;
`ifdef SEVSEG_LZB_EN
    if (d > 0 && (w >> (4*d)) == 16'h0000) n = 4'hA;
`endif
    return n;
  endfunction

  task automatic push_entry(input logic [15:0] w, input logic [3:0] m, input logic fd0, input int i);
    obs_t e;
    int d, t;
    t = i % 8;
    d = (i / 8) % 4;
    e.digit = 2'(d);
    e.num   = exp_num(w, d);
    e.en    = m[d] && (t >= 2);
    e.fd    = fd0 && (i == 0);
    exp_q.push_back(e);
  endtask

  task automatic check_cycle();
    obs_t e, o;
    o = '{digit: digit, num: num, en: en, fd: frame_done};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s cyc=%0d scoreboard empty observed=%h", tag, cyc, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs n cycles of a frame showing w/m; up to two one-cycle loads at given cycle indices.
  task automatic run_frame(input logic [15:0] w, input logic [3:0] m, input logic fd0, input int n,
                           input int la, input logic [15:0] lva, input logic [3:0] lma,
                           input int lb, input logic [15:0] lvb, input logic [3:0] lmb);
    for (int i = 0; i < n; i++) push_entry(w, m, fd0, i);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      if (i == la) begin load = 1'b1; value = lva; digit_en = lma; end
      else if (i == lb) begin load = 1'b1; value = lvb; digit_en = lmb; end
      advance();
      load = 1'b0;
    end
  endtask

  initial begin
    obs_t r;
    repeat (3) @(posedge clk);
    #1;
    r = '{digit: digit, num: num, en: en, fd: frame_done};
    checks++;
    assert (r === obs_t'(0)) else begin
      failures++;
      $error("FAIL reset_state observed=%h expected=%h", r, obs_t'(0));
    end
    rst = 1'b0;

    tag = "scan_first_frame";
    run_frame(16'h0000, 4'h0, 1'b0, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    tag = "load_mid_frame";
    run_frame(16'h0000, 4'h0, 1'b1, 32, 10, 16'h1234, 4'hF, -1, 16'h0, 4'h0);
    tag = "load_shown";
    run_frame(16'h1234, 4'hF, 1'b1, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    tag = "tearing_loads";
    run_frame(16'h1234, 4'hF, 1'b1, 32, 5, 16'hAAAA, 4'hF, 16, 16'h5678, 4'hF);
    tag = "tearing_shown";
    run_frame(16'h5678, 4'hF, 1'b1, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    tag = "boundary_load";
    run_frame(16'h5678, 4'hF, 1'b1, 32, 31, 16'h9999, 4'hF, -1, 16'h0, 4'h0);
    tag = "boundary_shown";
    run_frame(16'h9999, 4'hF, 1'b1, 32, 12, 16'hBCF0, 4'b0101, -1, 16'h0, 4'h0);

    tag = "mask_remap";
    run_frame(16'hBCF0, 4'b0101, 1'b1, 21, 3, 16'h1111, 4'hF, -1, 16'h0, 4'h0);
    push_entry(16'hBCF0, 4'b0101, 1'b1, 21);
    check_cycle();

    #2 rst = 1'b1;
    #1;
    r = '{digit: digit, num: num, en: en, fd: frame_done};
    checks++;
    assert (r === obs_t'(0)) else begin
      failures++;
      $error("FAIL async_reset observed=%h expected=%h", r, obs_t'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    tag = "post_reset_frame0";
    run_frame(16'h0000, 4'h0, 1'b0, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    tag = "pending_discarded";
    run_frame(16'h0000, 4'h0, 1'b1, 32, 4, 16'h0042, 4'hF, -1, 16'h0, 4'h0);
    tag = "leading_zero";
    run_frame(16'h0042, 4'hF, 1'b1, 32, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
